// File: rtl/reg_wb_arbiter.sv
// Register-file writeback arbiter: a load write, a 2-entry in-order ALU queue, or a direct ALU write may win each cycle.
// Optional read bypass over pending writes is enabled with `define REG_WB_ARBITER_BYPASS_EN.
module reg_wb_arbiter (
  input  logic        CLK,
  input  logic        Start,
  input  logic        alu_req,
  input  logic [2:0]  alu_reg,
  input  logic [15:0] alu_val,
  output logic        alu_ready,
  input  logic        mem_req,
  input  logic [2:0]  mem_reg,
  input  logic [15:0] mem_val,
  output logic        RegWrite,
  output logic [2:0]  writeReg,
  output logic [15:0] writeValue,
  output logic [1:0]  pend_count
`ifdef REG_WB_ARBITER_BYPASS_EN
  ,
  input  logic [2:0]  rd_addr,
  output logic        rd_hit,
  output logic [15:0] rd_val
`endif
);

  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } q_state_e;

  q_state_e    state, state_next;

  // Slot 0 is always the queue head (oldest entry).
  logic [2:0]  slot_reg      [2];
  logic [15:0] slot_val      [2];
  logic [2:0]  slot_reg_next [2];
  logic [15:0] slot_val_next [2];

  logic        mem_valid;
  logic        alu_take;
  logic        keep0, keep1;
  logic        direct, push;
  logic [1:0]  n_keep;
  logic [1:0]  n_total;
  logic        sel_valid;
  logic [2:0]  sel_reg;
  logic [15:0] sel_val;

  assign alu_ready  = (state != Q_FULL);
  assign pend_count = state;

  // NOTE: every signal written in this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    mem_valid     = mem_req && (mem_reg != 3'd0);
    alu_take      = alu_req && alu_ready && (alu_reg != 3'd0);
    keep0         = (state != Q_EMPTY);
    keep1         = (state == Q_FULL);
    direct        = 1'b0;
    sel_valid     = 1'b0;
    sel_reg       = 3'd0;
    sel_val       = 16'd0;
    slot_reg_next = slot_reg;
    slot_val_next = slot_val;
    n_keep        = 2'd0;
    state_next    = state;

    if (mem_valid) begin
      // The load is younger than every queued ALU write, so same-destination entries are stale.
      sel_valid = 1'b1;
      sel_reg   = mem_reg;
      sel_val   = mem_val;
      if (slot_reg[0] == mem_reg) keep0 = 1'b0;
      if (slot_reg[1] == mem_reg) keep1 = 1'b0;
    end else if (state != Q_EMPTY) begin
      sel_valid = 1'b1;
      sel_reg   = slot_reg[0];
      sel_val   = slot_val[0];
      keep0     = 1'b0;
    end else if (alu_take) begin
      sel_valid = 1'b1;
      sel_reg   = alu_reg;
      sel_val   = alu_val;
      direct    = 1'b1;
    end

    push = alu_take && !direct;

    case ({keep1, keep0})
      2'b11: n_keep = 2'd2;
      2'b01: n_keep = 2'd1;
      2'b10: begin
        slot_reg_next[0] = slot_reg[1];
        slot_val_next[0] = slot_val[1];
        n_keep           = 2'd1;
      end
      default: n_keep = 2'd0;
    endcase

    // Both slots survive only when full, and then alu_ready is low, so a push always finds room.
    if (push) begin
      if (n_keep == 2'd0) begin
        slot_reg_next[0] = alu_reg;
        slot_val_next[0] = alu_val;
      end else begin
        slot_reg_next[1] = alu_reg;
        slot_val_next[1] = alu_val;
      end
    end

    n_total = n_keep + {1'b0, push};
    case (n_total)
      2'd0:    state_next = Q_EMPTY;
      2'd1:    state_next = Q_ONE;
      default: state_next = Q_FULL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge Start) begin
    if (Start) begin
      state      <= Q_EMPTY;
      RegWrite   <= 1'b0;
      writeReg   <= 3'd0;
      writeValue <= 16'd0;
    end else begin
      state    <= state_next;
      RegWrite <= sel_valid;
      if (sel_valid) begin
        writeReg   <= sel_reg;
        writeValue <= sel_val;
      end
    end
  end

  // NOTE: queue payload is not reset; occupancy in state qualifies every use of these slots.
  always_ff @(posedge CLK) begin
    slot_reg <= slot_reg_next;
    slot_val <= slot_val_next;
  end

`ifdef REG_WB_ARBITER_BYPASS_EN
  // Later matches override earlier ones: output write < queue head < queue tail in age.
  always_comb begin
    rd_hit = 1'b0;
    rd_val = 16'd0;
    if (rd_addr != 3'd0) begin
      if (RegWrite && (writeReg == rd_addr)) begin
        rd_hit = 1'b1;
        rd_val = writeValue;
      end
      if ((state != Q_EMPTY) && (slot_reg[0] == rd_addr)) begin
        rd_hit = 1'b1;
        rd_val = slot_val[0];
      end
      if ((state == Q_FULL) && (slot_reg[1] == rd_addr)) begin
        rd_hit = 1'b1;
        rd_val = slot_val[1];
      end
    end
  end
`endif

endmodule
